jedro_1_test_checker: RTL and testbench

Parametrised end-of-test checker for jedro_1 instruction-level simulations. It waits for a start pulse, runs until the core flags a halt (illegal instruction) or a cycle budget expires, then drains the pipeline. It then reads back up to NUM_CHECKS register-file entries through a read port and compares each against an expected value. The block sits beside jedro_1_top in every directed instruction bench and replaces per-bench hand-written loop/assert code with one pass/fail/diagnostic result.

---
 rtl/jedro_1_test_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_jedro_1_test_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_test_checker.sv
// ---------------------------------------------------------------------------
// jedro_1_test_checker
//
// End-of-test checker for jedro_1 instruction-level benches. After a start
// pulse it counts RUN cycles until the core halts or the cycle budget runs
// out. It then waits a fixed number of drain cycles and reads up to
// NUM_CHECKS register-file entries, one per cycle, through an external
// combinational read port. Each read is compared against an expected value,
// and the result is reduced to a single pass flag plus diagnostics.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        start a test (honoured in IDLE and DONE only)
//   halt_i         core halt flag (illegal instruction), sampled in RUN
//   exp_addr_i     per-slot register address, slot k at [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   exp_data_i     per-slot expected value, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   exp_mask_i     slot k is compared only when bit k is set
//   rf_raddr_o     register-file read address (slot address in CHECK, else 0)
//   rf_rdata_i     register-file read data for rf_raddr_o
//   busy_o         RUN, DRAIN or CHECK
//   done_o         DONE
//   pass_o         no mismatch and no timeout (meaningful while done_o)
//   timeout_o      cycle budget expired without a halt
//   cycle_count_o  RUN cycles elapsed
//   fail_count_o   number of mismatching slots
//   fail_idx_o     slot of the first mismatch
//   fail_data_o    value read at the first mismatch
// ---------------------------------------------------------------------------
module jedro_1_test_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 4,
  parameter int MAX_CYCLES     = 64,
  parameter int DRAIN_CYCLES   = 3,
  localparam int CC_W  = $clog2(MAX_CYCLES + 1),
  localparam int FC_W  = $clog2(NUM_CHECKS + 1),
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 halt_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     exp_data_i,
  input  logic [NUM_CHECKS-1:0]                exp_mask_i,
  output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 timeout_o,
  output logic [CC_W-1:0]                      cycle_count_o,
  output logic [FC_W-1:0]                      fail_count_o,
  output logic [IDX_W-1:0]                     fail_idx_o,
  output logic [DATA_WIDTH-1:0]                fail_data_o
);

  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CC_W-1:0]  CC_LAST = CC_W'(MAX_CYCLES - 1);
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [CC_W-1:0]         cycle_count_reg, cycle_count_next;
  logic                    timeout_reg, timeout_next;
  logic [FC_W-1:0]         fail_count_reg, fail_count_next;
  logic [IDX_W-1:0]        fail_idx_reg, fail_idx_next;
  logic [DATA_WIDTH-1:0]   fail_data_reg, fail_data_next;
  logic [DR_W-1:0]         drain_cnt_reg, drain_cnt_next;
  logic [IDX_W-1:0]        slot_reg, slot_next;
  logic                    pass_reg, pass_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    mismatch;

  // Unpack the flat slot buses into arrays indexed by slot number.
  logic [REG_ADDR_WIDTH-1:0] slot_addr [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     slot_data [NUM_CHECKS];

  generate
    for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_slot
      assign slot_addr[gi] = exp_addr_i[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      assign slot_data[gi] = exp_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The register file answers combinationally, so the read address has to
  // follow the current slot directly rather than through a register.
  always_comb begin
    rf_raddr_o = '0;
    if (state_reg == S_CHECK) begin
      rf_raddr_o = slot_addr[slot_reg];
    end
  end

  assign mismatch = (state_reg == S_CHECK) && exp_mask_i[slot_reg] &&
                    (rf_rdata_i != slot_data[slot_reg]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= S_IDLE;
      cycle_count_reg <= '0;
      timeout_reg     <= 1'b0;
      fail_count_reg  <= '0;
      fail_idx_reg    <= '0;
      fail_data_reg   <= '0;
      drain_cnt_reg   <= '0;
      slot_reg        <= '0;
      pass_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cycle_count_reg <= cycle_count_next;
      timeout_reg     <= timeout_next;
      fail_count_reg  <= fail_count_next;
      fail_idx_reg    <= fail_idx_next;
      fail_data_reg   <= fail_data_next;
      drain_cnt_reg   <= drain_cnt_next;
      slot_reg        <= slot_next;
      pass_reg        <= pass_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cycle_count_next = cycle_count_reg;
    timeout_next     = timeout_reg;
    fail_count_next  = fail_count_reg;
    fail_idx_next    = fail_idx_reg;
    fail_data_next   = fail_data_reg;
    drain_cnt_next   = drain_cnt_reg;
    slot_next        = slot_reg;
    pass_next        = pass_reg;
    busy_next        = 1'b0;
    done_next        = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_next       = S_RUN;
          cycle_count_next = '0;
          timeout_next     = 1'b0;
          fail_count_next  = '0;
          fail_idx_next    = '0;
          fail_data_next   = '0;
          pass_next        = 1'b0;
        end
      end

      S_RUN: begin
        cycle_count_next = cycle_count_reg + 1'b1;
        drain_cnt_next   = '0;
        // A halt on the budget's last edge still counts as a clean halt.
        if (halt_i) begin
          state_next = S_DRAIN;
        end else if (cycle_count_reg == CC_LAST) begin
          state_next   = S_DRAIN;
          timeout_next = 1'b1;
        end
      end

      S_DRAIN: begin
        if (drain_cnt_reg == DR_LAST) begin
          state_next = S_CHECK;
          slot_next  = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          fail_count_next = fail_count_reg + 1'b1;
          if (fail_count_reg == '0) begin
            fail_idx_next  = slot_reg;
            fail_data_next = rf_rdata_i;
          end
        end
        // Masked slots still occupy their cycle so the latency is fixed.
        if (slot_reg == K_LAST) begin
          state_next = S_DONE;
          pass_next  = (fail_count_next == '0) && !timeout_reg;
        end else begin
          slot_next = slot_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next == S_RUN) || (state_next == S_DRAIN) ||
                (state_next == S_CHECK);
    done_next = (state_next == S_DONE);
  end

  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign pass_o        = pass_reg;
  assign timeout_o     = timeout_reg;
  assign cycle_count_o = cycle_count_reg;
  assign fail_count_o  = fail_count_reg;
  assign fail_idx_o    = fail_idx_reg;
  assign fail_data_o   = fail_data_reg;

endmodule

// File: tb/tb_jedro_1_test_checker.sv
module tb_jedro_1_test_checker;

  localparam int DW = 32, AW = 5, N = 4, MAXC = 64, DR = 3;
  localparam int DW2 = 64, N2 = 1, MAXC2 = 1, DR2 = 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, start_i, halt_i;
  logic [N-1:0][AW-1:0] ea;
  logic [N-1:0][DW-1:0] ed;
  logic [N-1:0]         em;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic busy, done, pass, tmo;
  logic [6:0]    ccnt;
  logic [2:0]    fcnt;
  logic [1:0]    fidx;
  logic [DW-1:0] fdata;
  logic [DW-1:0] rf [32];
  assign rdata = rf[raddr];

  logic start2, halt2;
  logic [0:0][AW-1:0]  ea2;
  logic [0:0][DW2-1:0] ed2;
  logic [0:0]          em2;
  logic [AW-1:0]  raddr2;
  logic [DW2-1:0] rdata2;
  logic busy2, done2, pass2, tmo2;
  logic [0:0]     ccnt2, fcnt2, fidx2;
  logic [DW2-1:0] fdata2;
  logic [DW2-1:0] rf2 [32];
  assign rdata2 = rf2[raddr2];

  jedro_1_test_checker #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(N),
    .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DR)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .exp_addr_i(ea), .exp_data_i(ed), .exp_mask_i(em),
    .rf_raddr_o(raddr), .rf_rdata_i(rdata),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .cycle_count_o(ccnt), .fail_count_o(fcnt), .fail_idx_o(fidx),
    .fail_data_o(fdata)
  );

  jedro_1_test_checker #(
    .DATA_WIDTH(DW2), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(N2),
    .MAX_CYCLES(MAXC2), .DRAIN_CYCLES(DR2)
  ) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start2), .halt_i(halt2),
    .exp_addr_i(ea2), .exp_data_i(ed2), .exp_mask_i(em2),
    .rf_raddr_o(raddr2), .rf_rdata_i(rdata2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .timeout_o(tmo2),
    .cycle_count_o(ccnt2), .fail_count_o(fcnt2), .fail_idx_o(fidx2),
    .fail_data_o(fdata2)
  );

  typedef struct {
    int              done_cyc;
    bit              pass;
    bit              tmo;
    int              ccnt;
    int              fcnt;
    int              fidx;
    longint unsigned fdata;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int txn = 0;
  logic done_seen = 1'b0, done2_seen = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string nm, longint unsigned act, longint unsigned want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: run length follows from the halt cycle or the budget, then a
  // fixed drain and one cycle per slot; slot results come from the regfile.
  function automatic exp_t model1(int halt_at, int start_edge);
    exp_t e;
    int run;
    if (halt_at >= 0 && halt_at < MAXC) begin run = halt_at + 1; e.tmo = 0; end
    else begin run = MAXC; e.tmo = 1; end
    e.ccnt = run;
    e.done_cyc = start_edge + run + DR + N;
    e.fcnt = 0; e.fidx = 0; e.fdata = 0;
    for (int k = 0; k < N; k++) begin
      if (em[k] && rf[ea[k]] != ed[k]) begin
        if (e.fcnt == 0) begin e.fidx = k; e.fdata = rf[ea[k]]; end
        e.fcnt++;
      end
    end
    e.pass = (e.fcnt == 0) && !e.tmo;
    return e;
  endfunction

  function automatic exp_t model2(int halt_at, int start_edge);
    exp_t e;
    int run;
    if (halt_at >= 0 && halt_at < MAXC2) begin run = halt_at + 1; e.tmo = 0; end
    else begin run = MAXC2; e.tmo = 1; end
    e.ccnt = run;
    e.done_cyc = start_edge + run + DR2 + N2;
    e.fcnt = 0; e.fidx = 0; e.fdata = 0;
    if (em2[0] && rf2[ea2[0]] != ed2[0]) begin
      e.fcnt = 1; e.fdata = rf2[ea2[0]];
    end
    e.pass = (e.fcnt == 0) && !e.tmo;
    return e;
  endfunction

  // Monitors: pop one expectation on each rising done.
  always @(negedge clk_i) begin
    if (done && !done_seen) begin
      txn++;
      $display("txn %0d dut: pass=%0b timeout=%0b cycles=%0d fails=%0d idx=%0d data=%0h at %0d",
               txn, pass, tmo, ccnt, fcnt, fidx, fdata, cyc);
      if (q1.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_cycle", cyc, q1[0].done_cyc);
        chk("pass", pass, q1[0].pass);
        chk("timeout", tmo, q1[0].tmo);
        chk("cycle_count", ccnt, q1[0].ccnt);
        chk("fail_count", fcnt, q1[0].fcnt);
        chk("fail_idx", fidx, q1[0].fidx);
        chk("fail_data", fdata, q1[0].fdata);
        chk("busy_at_done", busy, 0);
        q1.delete(0);
      end
    end
    done_seen <= done;
  end

  always @(negedge clk_i) begin
    if (done2 && !done2_seen) begin
      txn++;
      $display("txn %0d dut2: pass=%0b timeout=%0b cycles=%0d fails=%0d data=%0h at %0d",
               txn, pass2, tmo2, ccnt2, fcnt2, fdata2, cyc);
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        chk("d2_done_cycle", cyc, q2[0].done_cyc);
        chk("d2_pass", pass2, q2[0].pass);
        chk("d2_timeout", tmo2, q2[0].tmo);
        chk("d2_cycle_count", ccnt2, q2[0].ccnt);
        chk("d2_fail_count", fcnt2, q2[0].fcnt);
        chk("d2_fail_idx", fidx2, q2[0].fidx);
        chk("d2_fail_data", fdata2, q2[0].fdata);
        q2.delete(0);
      end
    end
    done2_seen <= done2;
  end

  task automatic wait_done1();
    for (int w = 0; w < 200 && !done; w++) begin @(posedge clk_i); #1; end
    chk("done_reached", done, 1);
    @(negedge clk_i); @(posedge clk_i); #1;
    chk("done_hold", done, 1);
  endtask

  // Called #1 after an edge. halt_at < 0 means no halt at all.
  task automatic do_run1(int halt_at, int hold);
    int n_end;
    q1.push_back(model1(halt_at, cyc + 1));
    start_i = 1; @(posedge clk_i); #1; start_i = 0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_ccnt", ccnt, 0);
    chk("start_tmo", tmo, 0);
    chk("start_fcnt", fcnt, 0);
    chk("start_fidx", fidx, 0);
    chk("start_fdata", fdata, 0);
    chk("run_raddr", raddr, 0);
    n_end = (halt_at >= 0) ? halt_at + 1 + hold : 2;
    for (int n = 1; n <= n_end; n++) begin
      halt_i  = (halt_at >= 0 && n >= halt_at + 1);
      start_i = (n == 2);  // stray start while busy must be ignored
      @(posedge clk_i); #1;
    end
    halt_i = 0; start_i = 0;
    wait_done1();
  endtask

  task automatic do_run2(int halt_at);
    q2.push_back(model2(halt_at, cyc + 1));
    start2 = 1; @(posedge clk_i); #1; start2 = 0;
    chk("d2_start_busy", busy2, 1);
    halt2 = (halt_at == 0); @(posedge clk_i); #1; halt2 = 0;
    for (int w = 0; w < 20 && !done2; w++) begin @(posedge clk_i); #1; end
    chk("d2_done_reached", done2, 1);
    @(negedge clk_i); @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; start_i = 0; halt_i = 0; start2 = 0; halt2 = 0;
    for (int i = 0; i < 32; i++) begin rf[i] = $urandom; rf2[i] = {$urandom, $urandom}; end
    ea = '0; ed = '0; em = '0; ea2 = '0; ed2 = '0; em2 = '0;
    repeat (2) @(posedge clk_i); #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_tmo", tmo, 0); chk("rst_ccnt", ccnt, 0); chk("rst_raddr", raddr, 0);
    rst_i = 0;
    @(posedge clk_i); #1;

    // blt-style pass
    rf[1] = 0; rf[2] = 7;
    ea[0] = 1; ed[0] = 0; ea[1] = 2; ed[1] = 7; ea[2] = 9; ed[2] = ~rf[9]; ea[3] = 3; ed[3] = ~rf[3];
    em = 4'b0011;
    do_run1(20, 0);

    // mismatch capture: slot1 and slot3 wrong
    rf[2] = 5; rf[3] = 9; rf[4] = 11;
    ea[0] = 1; ed[0] = 0; ea[1] = 2; ed[1] = 7; ea[2] = 3; ed[2] = 9; ea[3] = 4; ed[3] = 12;
    em = 4'b1111;
    do_run1(10, 2);

    // restart from DONE after the failing run
    ed[1] = 5; ed[3] = 11;
    do_run1(3, 1);

    // timeout, all match
    do_run1(-1, 0);

    // mask 0 hides mismatching data
    ed[0] = 32'hdead_beef; ed[2] = 32'h1234_5678;
    em = 4'b0000;
    do_run1(8, 0);

    // simultaneous halt and budget expiry
    em = 4'b1111; ed[0] = 0; ed[2] = 9;
    do_run1(MAXC - 1, 0);

    // reset mid-CHECK with start held
    start_i = 1; @(posedge clk_i); #1; start_i = 0;
    repeat (5) begin @(posedge clk_i); #1; end
    halt_i = 1; @(posedge clk_i); #1; halt_i = 0;
    repeat (DR + 1) begin @(posedge clk_i); #1; end
    chk("mid_check_busy", busy, 1);
    chk("mid_check_raddr", raddr, ea[1]);
    rst_i = 1; start_i = 1; @(posedge clk_i); #1; rst_i = 0; start_i = 0;
    chk("rst2_busy", busy, 0); chk("rst2_done", done, 0); chk("rst2_pass", pass, 0);
    chk("rst2_tmo", tmo, 0); chk("rst2_ccnt", ccnt, 0); chk("rst2_fcnt", fcnt, 0);
    chk("rst2_fidx", fidx, 0); chk("rst2_fdata", fdata, 0); chk("rst2_raddr", raddr, 0);
    @(posedge clk_i); #1;
    chk("rst2_idle", busy, 0);

    // randomized runs
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) rf[$urandom_range(0, 31)] = $urandom;
      for (int k = 0; k < N; k++) begin
        ea[k] = AW'($urandom_range(0, 31));
        ed[k] = rf[ea[k]];
        if ($urandom_range(0, 2) == 0) ed[k] = ed[k] ^ (32'h1 << $urandom_range(0, 31));
      end
      em = 4'($urandom_range(0, 15));
      do_run1(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, MAXC - 1)),
              int'($urandom_range(0, 4)));
    end

    // parameter sweep instance
    ea2[0] = 5; ed2[0] = rf2[5]; em2 = 1'b1;
    do_run2(-1);
    do_run2(0);
    ed2[0] = ~rf2[5];
    do_run2(0);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
